// File: rtl/crc_serial_param.sv
// Bit-serial CRC engine: GEN mode forwards the stream and appends the CRC,
// CHK mode absorbs stream plus CRC and reports whether the residual matched.
module crc_serial_param #(
  parameter int               CRC_W    = 5,
  parameter logic [CRC_W-1:0] POLY     = CRC_W'(5'h05),
  parameter logic [CRC_W-1:0] INIT     = CRC_W'(5'h1F),
  parameter bit               INV_OUT  = 1'b1,
  parameter logic [CRC_W-1:0] RESIDUAL = CRC_W'(5'h0C)
) (
  input  logic clk,
  input  logic rst,
  input  logic mode_chk,
  input  logic inb,
  input  logic recving,
  input  logic pause_out,
  output logic pause_in,
  output logic outb,
  output logic sending,
  output logic crc_done,
  output logic crc_ok
);

  localparam int CNT_W = (CRC_W > 2) ? $clog2(CRC_W) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_SEND   = 2'd2;
  localparam logic [1:0] S_RESULT = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CRC_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             take;

  // One LFSR step with the incoming bit folded into the feedback tap.
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] r,
                                                input logic b);
    logic fb;
    fb = r[CRC_W-1] ^ b;
    return {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  endfunction

  assign take = recving & ~pause_out;

  always_comb begin
    // NOTE: every output and next-state gets a default first so no path through
    // the case statement can leave a value unassigned and infer a latch.
    state_d  = state_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    pause_in = 1'b0;
    outb     = 1'b0;
    sending  = 1'b0;
    crc_done = 1'b0;
    crc_ok   = 1'b0;

    case (state_q)
      S_IDLE: begin
        rem_d = INIT;
        cnt_d = '0;
        // The first bit of a stream is handled as a DATA bit, mode taken live.
        if (recving) begin
          mode_d   = mode_chk;
          state_d  = S_DATA;
          pause_in = pause_out;
          sending  = ~mode_chk;
          outb     = inb & ~mode_chk;
          if (take) rem_d = crc_step(INIT, inb);
        end
      end

      S_DATA: begin
        pause_in = pause_out;
        if (recving) begin
          sending = ~mode_q;
          outb    = inb & ~mode_q;
          if (take) rem_d = crc_step(rem_q, inb);
        end else begin
          state_d = mode_q ? S_RESULT : S_SEND;
          cnt_d   = '0;
        end
      end

      S_SEND: begin
        sending  = 1'b1;
        pause_in = 1'b1;
        outb     = rem_q[CRC_W-1] ^ INV_OUT;
        if (!pause_out) begin
          rem_d = {rem_q[CRC_W-2:0], 1'b0};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(CRC_W-1)) begin
            crc_done = 1'b1;
            state_d  = S_IDLE;
            rem_d    = INIT;
            cnt_d    = '0;
          end
        end
      end

      default: begin
        crc_done = 1'b1;
        crc_ok   = (rem_q == RESIDUAL);
        pause_in = 1'b1;
        state_d  = S_IDLE;
        rem_d    = INIT;
      end
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every register samples
  // the pre-edge values; reset is synchronous and overrides the whole state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= INIT;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

endmodule

// File: tb/tb_crc_serial_param.sv
// Self-checking bench for crc_serial_param: CRC5 and CRC16 instances driven
// from vector tables, scripted corner cases and randomised streams.
module tb_crc_serial_param;

  typedef bit bq_t[$];
  typedef struct {
    bit          is16;
    bit          chk;
    int          n;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst, mode_chk, inb, recving, pause_out;
  logic rv5, rv16;
  logic pi5, ob5, sd5, dn5, ok5;
  logic pi16, ob16, sd16, dn16, ok16;
  logic pi, ob, sd, dn, ok;
  bit   sel16 = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  // Each stream is routed to one instance only so the other stays idle.
  assign rv5  = recving & ~sel16;
  assign rv16 = recving & sel16;
  assign pi   = sel16 ? pi16 : pi5;
  assign ob   = sel16 ? ob16 : ob5;
  assign sd   = sel16 ? sd16 : sd5;
  assign dn   = sel16 ? dn16 : dn5;
  assign ok   = sel16 ? ok16 : ok5;

  crc_serial_param u_crc5 (
    .clk(clk), .rst(rst), .mode_chk(mode_chk), .inb(inb), .recving(rv5),
    .pause_out(pause_out), .pause_in(pi5), .outb(ob5), .sending(sd5),
    .crc_done(dn5), .crc_ok(ok5)
  );

  crc_serial_param #(
    .CRC_W(16), .POLY(16'h8005), .INIT(16'hFFFF), .INV_OUT(1'b1),
    .RESIDUAL(16'h800D)
  ) u_crc16 (
    .clk(clk), .rst(rst), .mode_chk(mode_chk), .inb(inb), .recving(rv16),
    .pause_out(pause_out), .pause_in(pi16), .outb(ob16), .sending(sd16),
    .crc_done(dn16), .crc_ok(ok16)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference remainder by polynomial long division of the augmented message:
  // (INIT * x^n + M(x) * x^w) mod G, returned MSB-aligned in bits [w-1:0].
  function automatic logic [31:0] model_rem(input int w, input logic [31:0] poly,
                                            input logic [31:0] init, input bq_t bits);
    bit          a[$];
    int          n;
    logic [31:0] r;
    n = bits.size();
    a = bits;
    for (int i = 0; i < w; i++) a.push_back(1'b0);
    for (int i = 0; i < w; i++) a[i] = a[i] ^ init[w-1-i];
    for (int i = 0; i < n; i++)
      if (a[i])
        for (int j = 1; j <= w; j++) a[i+j] = a[i+j] ^ poly[w-j];
    r = '0;
    for (int j = 0; j < w; j++) r[w-1-j] = a[n+j];
    return r;
  endfunction

  function automatic bq_t to_q(input logic [31:0] d, input int n);
    bq_t q;
    for (int i = n - 1; i >= 0; i--) q.push_back(d[i]);
    return q;
  endfunction

  // Drives one stream cycle by cycle and checks every visible output.
  // GEN: exp_val holds the appended CRC bits; CHK: exp_val[0] is the verdict.
  task automatic run_stream(input bit is16, input bit chk, input bq_t bits,
                            input logic [31:0] exp_val, input bit rnd_pause,
                            input int dp_at, input int dp_len,
                            input int cp_at, input int cp_len,
                            input bit hold_recv, input int abort_at);
    int w;
    int i;
    int k;
    int pc;
    bit p;
    bit first;
    w = is16 ? 16 : 5;
    if (sel16 != is16) begin
      recving = 1'b0;
      sel16   = is16;
    end
    i = 0; pc = 0; first = 1'b1;
    while (i < bits.size()) begin
      @(negedge clk);
      p = (i == dp_at && pc < dp_len) || (rnd_pause && $urandom_range(3) == 0);
      if (i == dp_at && p) pc++;
      recving   = 1'b1;
      inb       = bits[i];
      pause_out = p;
      mode_chk  = first ? chk : 1'($urandom_range(1));
      first     = 1'b0;
      #1;
      check("data_sending", sd, !chk);
      if (!chk) check("data_outb", ob, bits[i]);
      check("data_pause_in", pi, p);
      check("data_no_done", dn, 0);
      if (!p) i++;
    end
    @(negedge clk);
    recving   = 1'b0;
    pause_out = 1'b0;
    mode_chk  = 1'($urandom_range(1));
    #1;
    check("end_sending", sd, 0);
    check("end_no_done", dn, 0);
    check("end_pause_in", pi, 0);
    if (chk) begin
      @(negedge clk);
      #1;
      check("result_done", dn, 1);
      check("result_ok", ok, exp_val[0]);
      check("result_pause_in", pi, 1);
      check("result_sending", sd, 0);
    end else begin
      k = 0; pc = 0;
      while (k < w) begin
        @(negedge clk);
        p = (k == cp_at && pc < cp_len) || (rnd_pause && $urandom_range(3) == 0);
        if (k == cp_at && p) pc++;
        pause_out = p;
        recving   = hold_recv;
        inb       = 1'($urandom_range(1));
        if (k == abort_at) begin
          rst       = 1'b1;
          pause_out = 1'b0;
          recving   = 1'b0;
          #1;
          check("abort_no_done", dn, 0);
          @(posedge clk);
          @(negedge clk);
          rst = 1'b0;
          #1;
          check("abort_sending", sd, 0);
          check("abort_outb", ob, 0);
          check("abort_pause_in", pi, 0);
          check("abort_done", dn, 0);
          return;
        end
        #1;
        check("send_sending", sd, 1);
        check("send_pause_in", pi, 1);
        check("send_outb", ob, exp_val[w-1-k]);
        check("send_done", dn, (k == w - 1) && !p);
        check("send_ok", ok, 0);
        if (!p) k++;
      end
    end
  endtask

  task automatic idle_check(input string name);
    @(negedge clk);
    recving   = 1'b0;
    pause_out = 1'b0;
    #1;
    check({name, "_sending"}, sd, 0);
    check({name, "_done"}, dn, 0);
    check({name, "_pause_in"}, pi, 0);
  endtask

  initial begin
    vec_t        tbl[5];
    bq_t         q;
    bq_t         zeros11;
    logic [31:0] c;
    logic [31:0] mask;
    logic [31:0] poly;
    logic [31:0] init;
    logic [31:0] res;
    logic [31:0] ev;
    int          w;
    int          n;
    bit          r16;
    bit          rchk;

    tbl[0] = '{1'b0, 1'b0, 11, 32'h0000, 32'h08};
    tbl[1] = '{1'b0, 1'b1, 16, 32'h0008, 32'h1};
    tbl[2] = '{1'b0, 1'b1, 16, 32'h0009, 32'h0};
    tbl[3] = '{1'b0, 1'b1, 16, 32'h0408, 32'h0};
    tbl[4] = '{1'b0, 1'b1, 16, 32'h0018, 32'h0};
    zeros11 = to_q(32'h0, 11);

    rst = 1'b1; mode_chk = 1'b0; inb = 1'b0; recving = 1'b0; pause_out = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_sending", sd, 0);
    check("reset_outb", ob, 0);
    check("reset_pause_in", pi, 0);
    check("reset_done", dn, 0);
    check("reset_ok", ok, 0);
    rst = 1'b0;

    // Empty stream: recving never rises, nothing is appended.
    repeat (3) idle_check("empty");

    foreach (tbl[t])
      run_stream(tbl[t].is16, tbl[t].chk, to_q(tbl[t].data, tbl[t].n), tbl[t].exp,
                 1'b0, -1, 0, -1, 0, 1'b0, -1);

    // Pauses mid-data and on CRC bit 2 leave the emitted sequence unchanged.
    run_stream(1'b0, 1'b0, zeros11, 32'h08, 1'b0, 5, 1, 2, 2, 1'b0, -1);

    // Reset during the append aborts; the next stream is unaffected.
    run_stream(1'b0, 1'b0, zeros11, 32'h08, 1'b0, -1, 0, -1, 0, 1'b0, 3);
    run_stream(1'b0, 1'b0, zeros11, 32'h08, 1'b0, -1, 0, -1, 0, 1'b0, -1);

    // CRC16: GEN of one zero byte, then CHK of byte plus that CRC.
    q = to_q(32'h0, 8);
    c = ~model_rem(16, 32'h8005, 32'hFFFF, q) & 32'hFFFF;
    run_stream(1'b1, 1'b0, q, c, 1'b0, -1, 0, -1, 0, 1'b0, -1);
    for (int i = 15; i >= 0; i--) q.push_back(c[i]);
    run_stream(1'b1, 1'b1, q, 32'h1, 1'b0, -1, 0, -1, 0, 1'b0, -1);
    q[3] = ~q[3];
    run_stream(1'b1, 1'b1, q, 32'h0, 1'b0, -1, 0, -1, 0, 1'b0, -1);

    // Back-to-back GEN streams with recving held high through the append.
    q = to_q(32'h2D5, 10);
    c = ~model_rem(5, 32'h05, 32'h1F, q) & 32'h1F;
    run_stream(1'b0, 1'b0, q, c, 1'b0, -1, 0, -1, 0, 1'b1, -1);
    q = to_q(32'h0B3, 9);
    c = ~model_rem(5, 32'h05, 32'h1F, q) & 32'h1F;
    run_stream(1'b0, 1'b0, q, c, 1'b0, -1, 0, -1, 0, 1'b1, -1);
    idle_check("b2b_tail");

    for (int t = 0; t < 30; t++) begin
      r16  = 1'($urandom_range(1));
      rchk = 1'($urandom_range(1));
      w    = r16 ? 16 : 5;
      mask = r16 ? 32'hFFFF : 32'h1F;
      poly = r16 ? 32'h8005 : 32'h05;
      init = r16 ? 32'hFFFF : 32'h1F;
      res  = r16 ? 32'h800D : 32'h0C;
      n    = $urandom_range(40, 1);
      q    = {};
      for (int i = 0; i < n; i++) q.push_back(1'($urandom_range(1)));
      if (rchk) begin
        if ($urandom_range(1) == 1) begin
          c = ~model_rem(w, poly, init, q) & mask;
          for (int i = w - 1; i >= 0; i--) q.push_back(c[i]);
        end
        ev = {31'b0, (model_rem(w, poly, init, q) == res)};
      end else begin
        ev = ~model_rem(w, poly, init, q) & mask;
      end
      run_stream(r16, rchk, q, ev, 1'b1, -1, 0, -1, 0, 1'($urandom_range(1)), -1);
      if ($urandom_range(1) == 1) idle_check("rnd_gap");
    end
    idle_check("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
